// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// Returns {remainder, quotient} with a one-cycle done pulse.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   div_data1_i,
    input  logic [DATA_WIDTH-1:0]   div_data2_i,
    input  logic                    div_signed_i,
    input  logic                    div_start_i,
    input  logic                    cancel_i,
    output logic [2*DATA_WIDTH-1:0] div_result_o,
    output logic                    div_done_o,
    output logic                    busy_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] quot;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] divisor;
    logic [CW-1:0]         count;
    logic                  neg_q;
    logic                  neg_r;

    logic                  accept;
    logic                  abort;
    logic                  last;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] diff;
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quot;
    logic [DATA_WIDTH-1:0] fix_rem;
    logic [DATA_WIDTH-1:0] fix_quot;

    // Operand magnitudes and handshake qualifiers.
    always_comb begin
        a_abs  = (div_signed_i && div_data1_i[DATA_WIDTH-1]) ? -div_data1_i : div_data1_i;
        b_abs  = (div_signed_i && div_data2_i[DATA_WIDTH-1]) ? -div_data2_i : div_data2_i;
        accept = div_start_i && !cancel_i;
        abort  = cancel_i || !div_start_i;
        last   = (count == CW'(DATA_WIDTH - 1));
    end

    // One restoring step plus sign fix-up of the step's outcome.
    always_comb begin
        shifted = {rem, quot[DATA_WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        if (diff[DATA_WIDTH+1]) begin
            step_rem  = shifted[DATA_WIDTH-1:0];
            step_quot = {quot[DATA_WIDTH-2:0], 1'b0};
        end else begin
            step_rem  = diff[DATA_WIDTH-1:0];
            step_quot = {quot[DATA_WIDTH-2:0], 1'b1};
        end
        fix_quot = neg_q ? -step_quot : step_quot;
        fix_rem  = neg_r ? -step_rem  : step_rem;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (div_data2_i == '0) ? ZERO : RUN;
                end
            end
            ZERO:    next_state = abort ? IDLE : DONE;
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers, result and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            quot         <= '0;
            rem          <= '0;
            divisor      <= '0;
            count        <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_result_o <= '0;
            div_done_o   <= 1'b0;
        end else begin
            div_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg_q   <= div_signed_i && (div_data1_i[DATA_WIDTH-1] ^ div_data2_i[DATA_WIDTH-1]);
                        neg_r   <= div_signed_i && div_data1_i[DATA_WIDTH-1];
                        divisor <= b_abs;
                        // The zero-divisor path needs the raw dividend, so it is parked in quot.
                        quot    <= (div_data2_i == '0) ? div_data1_i : a_abs;
                        rem     <= '0;
                        count   <= '0;
                    end
                end
                ZERO: begin
                    if (!abort) begin
                        div_result_o <= {quot, {DATA_WIDTH{1'b1}}};
                        div_done_o   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        rem   <= step_rem;
                        quot  <= step_quot;
                        count <= count + 1'b1;
                        if (last) begin
                            div_result_o <= {fix_rem, fix_quot};
                            div_done_o   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule
